// File: rtl/disp_rd_pkg.sv
// Shared types and default constants for the display read scheduler.
package disp_rd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        CHECK = 3'd2,
        REQ   = 3'd3,
        DATA  = 3'd4
    } state_t;

    localparam int DEF_ADDR_W       = 28;
    localparam int DEF_FRAME_BASE   = 0;
    localparam int DEF_FRAME_STRIDE = 2097152;
    localparam int DEF_FRAME_WORDS  = 2073600;
    localparam int DEF_BURST_LEN    = 64;
    localparam int DEF_FIFO_DEPTH   = 1024;
    localparam int DEF_CNT_W        = 11;

    // Burst length for the next request: the full burst, or whatever is left of the frame.
    function automatic logic [7:0] burst_words(input int unsigned left, input int unsigned burst);
        return (left < burst) ? 8'(left) : 8'(burst);
    endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Registers the vertical sync and emits a one-cycle frame_start on a 1-to-0 sample pair.
module vsync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic v_sync,
    output logic frame_start
);

    logic vs_smp;
    logic vs_hist;

    // Both samples reset high so a low sync during reset release still reads as a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_smp      <= 1'b1;
            vs_hist     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vs_smp      <= v_sync;
            vs_hist     <= vs_smp;
            frame_start <= vs_hist & ~vs_smp;
        end
    end

endmodule

// File: rtl/disp_rd_scheduler.sv
// Display-side DDR3 burst-read scheduler feeding the pixel read FIFO.
// Optional double buffering between two frame banks is enabled by DISP_DBL_BUF_EN.
module disp_rd_scheduler
    import disp_rd_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FRAME_BASE   = DEF_FRAME_BASE,
    parameter int FRAME_STRIDE = DEF_FRAME_STRIDE,
    parameter int FRAME_WORDS  = DEF_FRAME_WORDS,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              Sys_clk,
    input  logic              Rst,
    input  logic              V_Sync_sign,
    input  logic [CNT_W-1:0]  fifo_wr_cnt,
    input  logic              fifo_rd_en,
    input  logic              fifo_empty,
    output logic              fifo_clr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_len,
    input  logic              rd_ack,
    input  logic              rd_data_valid,
    input  logic              wr_frame_done,
    output logic              underflow,
    output logic              busy
);

`ifdef DISP_DBL_BUF_EN
    localparam bit DBL_BUF = 1'b1;
`else
    localparam bit DBL_BUF = 1'b0;
`endif

    localparam int WL_W = $clog2(FRAME_WORDS + 1);

    state_t            state, state_nxt;
    logic              frame_start;
    logic [ADDR_W-1:0] addr_ptr;
    logic [WL_W-1:0]   words_left;
    logic [7:0]        cur_len;
    logic [7:0]        burst_len_q;
    logic [7:0]        beat_cnt;
    logic              restart_pend;
    logic              bank, bank_nxt;
    logic              swap_pend;
    logic              space_ok;
    logic              beat_last;

    vsync_edge_det u_vsync (
        .clk         (Sys_clk),
        .rst         (Rst),
        .v_sync      (V_Sync_sign),
        .frame_start (frame_start)
    );

    function automatic logic [ADDR_W-1:0] bank_base(input logic b);
        return ADDR_W'(FRAME_BASE) + (b ? ADDR_W'(FRAME_STRIDE) : '0);
    endfunction

    always_comb begin
        cur_len   = burst_words(32'(words_left), 32'(BURST_LEN));
        space_ok  = (32'(fifo_wr_cnt) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
        beat_last = rd_data_valid && ((beat_cnt + 8'd1) == burst_len_q);
        bank_nxt  = bank ^ (DBL_BUF & swap_pend);
    end

    always_comb begin
        state_nxt = state;
        fifo_clr  = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        rd_len    = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = ARM;
            end
            ARM: begin
                fifo_clr  = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (frame_start)             state_nxt = ARM;
                else if (words_left == '0)   state_nxt = IDLE;
                else if (space_ok)           state_nxt = REQ;
            end
            REQ: begin
                rd_req  = 1'b1;
                rd_addr = addr_ptr;
                rd_len  = cur_len;
                // An acknowledge coinciding with a frame start still commits the burst.
                if (rd_ack)           state_nxt = DATA;
                else if (frame_start) state_nxt = ARM;
            end
            DATA: begin
                if (beat_last) state_nxt = (restart_pend || frame_start) ? ARM : CHECK;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Sys_clk) begin
        if (Rst) begin
            state        <= IDLE;
            addr_ptr     <= ADDR_W'(FRAME_BASE);
            words_left   <= '0;
            burst_len_q  <= '0;
            beat_cnt     <= '0;
            restart_pend <= 1'b0;
            bank         <= 1'b0;
            swap_pend    <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_rd_en && fifo_empty) underflow <= 1'b1;
            // A completion pulse landing in ARM stays pending for the following frame.
            swap_pend <= DBL_BUF && (wr_frame_done || (swap_pend && state != ARM));
            case (state)
                ARM: begin
                    bank         <= bank_nxt;
                    addr_ptr     <= bank_base(bank_nxt);
                    words_left   <= WL_W'(FRAME_WORDS);
                    restart_pend <= 1'b0;
                end
                REQ: begin
                    if (rd_ack) begin
                        addr_ptr    <= addr_ptr + ADDR_W'(cur_len);
                        words_left  <= words_left - WL_W'(cur_len);
                        burst_len_q <= cur_len;
                        beat_cnt    <= '0;
                        if (frame_start) restart_pend <= 1'b1;
                    end
                end
                DATA: begin
                    if (frame_start)   restart_pend <= 1'b1;
                    if (rd_data_valid) beat_cnt     <= beat_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_rd_scheduler.sv
// Directed bench for disp_rd_scheduler with a small frame (200 words, 64-word bursts).
module tb_disp_rd_scheduler;

`ifdef DISP_DBL_BUF_EN
    localparam int EXP_B1 = 1000;
`else
    localparam int EXP_B1 = 0;
`endif

    logic        Sys_clk = 1'b0;
    logic        Rst = 1'b1;
    logic        V_Sync_sign = 1'b1;
    logic [10:0] fifo_wr_cnt = '0;
    logic        fifo_rd_en = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        rd_ack = 1'b0;
    logic        rd_data_valid = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic        fifo_clr, rd_req, underflow, busy;
    logic [27:0] rd_addr;
    logic [7:0]  rd_len;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Sys_clk = ~Sys_clk;

    disp_rd_scheduler #(
        .ADDR_W(28), .FRAME_BASE(0), .FRAME_STRIDE(1000), .FRAME_WORDS(200),
        .BURST_LEN(64), .FIFO_DEPTH(1024), .CNT_W(11)
    ) dut (
        .Sys_clk(Sys_clk), .Rst(Rst), .V_Sync_sign(V_Sync_sign),
        .fifo_wr_cnt(fifo_wr_cnt), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
        .fifo_clr(fifo_clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ack(rd_ack), .rd_data_valid(rd_data_valid), .wr_frame_done(wr_frame_done),
        .underflow(underflow), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(negedge Sys_clk);
        Rst = 1'b0;
    endtask

    // Fall of the sync; fifo_clr must appear exactly two cycles after the low sample.
    task automatic frame_fall();
        @(negedge Sys_clk);
        V_Sync_sign = 1'b0;
        @(negedge Sys_clk);
        @(negedge Sys_clk);
        chk("clr_early", fifo_clr, 0);
        @(negedge Sys_clk);
        chk("clr_lat", fifo_clr, 1);
        chk("busy_arm", busy, 1);
        V_Sync_sign = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rd_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge Sys_clk);
        end
        if (!ok) chk("req_timeout", rd_req, 1);
    endtask

    // One burst: check request, ack one cycle later, return exp_len beats.
    task automatic do_burst(input int exp_addr, input int exp_len, input int vs_beat, input bit wfd);
        bit ok;
        bit saw_clr;
        saw_clr = 1'b0;
        wait_req(ok);
        if (ok) begin
            chk("rd_addr", rd_addr, exp_addr);
            chk("rd_len", rd_len, exp_len);
            rd_ack = 1'b1;
            @(negedge Sys_clk);
            rd_ack = 1'b0;
            chk("req_drop", rd_req, 0);
            for (int b = 1; b <= exp_len; b++) begin
                if (fifo_clr) saw_clr = 1'b1;
                rd_data_valid = 1'b1;
                if (b == vs_beat) V_Sync_sign = 1'b0;
                wr_frame_done = (wfd && b == 5);
                @(negedge Sys_clk);
            end
            rd_data_valid = 1'b0;
            wr_frame_done = 1'b0;
            V_Sync_sign   = 1'b1;
            if (vs_beat != 0) begin
                chk("clr_in_burst", saw_clr, 0);
                chk("clr_restart", fifo_clr, 1);
            end
        end
    endtask

    task automatic run_frame(input int base, input bit wfd);
        frame_fall();
        for (int k = 0; k < 4; k++)
            do_burst(base + k * 64, (k < 3) ? 64 : 8, 0, wfd && k == 1);
        repeat (2) @(negedge Sys_clk);
        chk("busy_idle", busy, 0);
        chk("req_idle", rd_req, 0);
    endtask

    initial begin
        bit ok;
        bit saw_req;

        // Reset state
        repeat (3) @(negedge Sys_clk);
        chk("rst_clr", fifo_clr, 0);
        chk("rst_req", rd_req, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_len", rd_len, 0);
        Rst = 1'b0;
        repeat (3) @(negedge Sys_clk);

        // Full frame: 64,64,64,8 at 0,64,128,192
        run_frame(0, 1'b0);

        // FIFO space gating, then reset while requesting
        fifo_wr_cnt = 11'd970;
        frame_fall();
        saw_req = 1'b0;
        repeat (8) begin
            @(negedge Sys_clk);
            if (rd_req) saw_req = 1'b1;
        end
        chk("req_hold", saw_req, 0);
        fifo_wr_cnt = 11'd960;
        @(negedge Sys_clk);
        chk("req_space_lat", rd_req, 1);
        Rst = 1'b1;
        @(negedge Sys_clk);
        chk("rst_req_drop", rd_req, 0);
        chk("rst_busy_drop", busy, 0);
        Rst = 1'b0;
        fifo_wr_cnt = '0;
        rd_data_valid = 1'b1;
        repeat (5) @(negedge Sys_clk);
        rd_data_valid = 1'b0;
        chk("busy_stray_beats", busy, 0);
        chk("req_stray_beats", rd_req, 0);

        // Frame restart at beat 10 of the second burst
        repeat (3) @(negedge Sys_clk);
        frame_fall();
        do_burst(0, 64, 0, 1'b0);
        do_burst(64, 64, 10, 1'b0);
        wait_req(ok);
        if (ok) begin
            chk("restart_addr", rd_addr, 0);
            chk("restart_len", rd_len, 64);
        end
        do_reset();

        // Sticky underflow through two frames
        repeat (2) @(negedge Sys_clk);
        fifo_rd_en = 1'b1;
        fifo_empty = 1'b1;
        @(negedge Sys_clk);
        fifo_rd_en = 1'b0;
        fifo_empty = 1'b0;
        chk("uf_set", underflow, 1);
        run_frame(0, 1'b0);
        chk("uf_hold1", underflow, 1);
        run_frame(0, 1'b0);
        chk("uf_hold2", underflow, 1);
        do_reset();
        chk("uf_rst", underflow, 0);

        // Bank swap request mid-frame (bank 1 only when double buffering is built in)
        repeat (2) @(negedge Sys_clk);
        run_frame(0, 1'b1);
        run_frame(EXP_B1, 1'b0);
        run_frame(EXP_B1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
